pzcorebus_1_to_m_switch_order_guard: RTL and testbench

- Command-path scheduler placed in front of the request side of a 1-to-M corebus switch.
- Guarantees that non-posted responses return to the single slave in command order. A non-posted command to a different master port is blocked until every response from the current port has drained.
- Tracks the outstanding non-posted count and the active destination port with a small FSM. Pass-through is zero-latency and combinational.

---
 rtl/pzcorebus_order_guard_pkg.sv | 17 +
 rtl/pzcorebus_order_guard_counter.sv | 57 +++++
 rtl/pzcorebus_1_to_m_switch_order_guard.sv | 165 ++++++++++++++++
 tb/tb_pzcorebus_1_to_m_switch_order_guard.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pzcorebus_order_guard_pkg.sv
// rtl/pzcorebus_order_guard_pkg.sv - shared types and helpers for the 1-to-M switch order guard
// Contents:
//   pzcorebus_order_guard_state : scheduler FSM states (IDLE, ACTIVE, DRAIN)
//   calc_count_width(max)       : bits needed to hold 0..max
package pzcorebus_order_guard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } pzcorebus_order_guard_state;

  function automatic int calc_count_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/pzcorebus_order_guard_counter.sv
// rtl/pzcorebus_order_guard_counter.sv - saturating up/down outstanding counter
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_inc, i_dec   : count up / count down requests (both together cancel)
//   o_count        : current count
//   o_zero, o_full : count == 0 / count == MAX
//   o_next_zero    : count will be 0 after this edge
//   o_underflow    : decrement requested while already zero (ignored)
module pzcorebus_order_guard_counter
  import pzcorebus_order_guard_pkg::*;
#(
  parameter int MAX   = 8,
  parameter int WIDTH = calc_count_width(MAX)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero,
  output logic             o_full,
  output logic             o_next_zero,
  output logic             o_underflow
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic             do_inc;
  logic             do_dec;

  assign o_zero      = (count == '0);
  assign o_full      = (count == WIDTH'(MAX));
  assign do_inc      = i_inc & ~o_full;
  assign do_dec      = i_dec & ~o_zero;
  assign o_underflow = i_dec & o_zero;

  always_comb begin
    count_next = count;
    if (do_inc && !do_dec) begin
      count_next = count + WIDTH'(1);
    end else if (!do_inc && do_dec) begin
      count_next = count - WIDTH'(1);
    end
  end

  assign o_next_zero = (count_next == '0);
  assign o_count     = count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/pzcorebus_1_to_m_switch_order_guard.sv
// rtl/pzcorebus_1_to_m_switch_order_guard.sv - keeps non-posted responses in command order across a 1-to-M switch
// Optional watchdog: define PZCOREBUS_1_TO_M_SWITCH_ORDER_GUARD_TIMEOUT_EN.
// Ports:
//   i_clk, i_rst                        : clock, synchronous active-high reset
//   i_scmd_valid / o_scmd_accept        : command handshake with the slave side
//   i_scmd_select, i_scmd_non_posted    : destination port and response expectation of the command
//   o_mcmd_valid / i_mcmd_accept        : gated handshake towards the request switch
//   i_resp_valid, i_resp_accept, i_resp_last : merged response path observation
//   o_active_select, o_outstanding      : port owning outstanding responses, their count
//   o_busy, o_error, o_timeout          : FSM not idle, sticky underflow, sticky drain timeout
module pzcorebus_1_to_m_switch_order_guard
  import pzcorebus_order_guard_pkg::*;
#(
  parameter int MASTERS         = 2,
  parameter int SELECT_WIDTH    = (MASTERS > 1) ? $clog2(MASTERS) : 1,
  parameter int MAX_OUTSTANDING = 8,
  parameter int COUNT_WIDTH     = calc_count_width(MAX_OUTSTANDING),
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_scmd_valid,
  output logic                    o_scmd_accept,
  input  logic [SELECT_WIDTH-1:0] i_scmd_select,
  input  logic                    i_scmd_non_posted,
  output logic                    o_mcmd_valid,
  input  logic                    i_mcmd_accept,
  input  logic                    i_resp_valid,
  input  logic                    i_resp_accept,
  input  logic                    i_resp_last,
  output logic [SELECT_WIDTH-1:0] o_active_select,
  output logic [COUNT_WIDTH-1:0]  o_outstanding,
  output logic                    o_busy,
  output logic                    o_error,
  output logic                    o_timeout
);

  pzcorebus_order_guard_state state;
  pzcorebus_order_guard_state state_next;

  logic [SELECT_WIDTH-1:0] active_select;
  logic                    error;
  logic                    allow;
  logic                    same_port;
  logic                    cmd_fire;
  logic                    np_fire;
  logic                    resp_done;
  logic                    cnt_zero;
  logic                    cnt_full;
  logic                    cnt_next_zero;
  logic                    cnt_underflow;

  assign same_port = (i_scmd_select == active_select);

  // Posted commands never produce responses, so they can never reorder them.
  always_comb begin
    allow = 1'b0;
    if (!i_scmd_non_posted) begin
      allow = 1'b1;
    end else begin
      case (state)
        IDLE:    allow = 1'b1;
        ACTIVE:  allow = same_port & ~cnt_full;
        default: allow = 1'b0;
      endcase
    end
  end

  assign o_mcmd_valid  = i_scmd_valid & allow;
  assign o_scmd_accept = i_mcmd_accept & allow;

  assign cmd_fire  = o_mcmd_valid & i_mcmd_accept;
  assign np_fire   = cmd_fire & i_scmd_non_posted;
  assign resp_done = i_resp_valid & i_resp_accept & i_resp_last;

  pzcorebus_order_guard_counter #(
    .MAX   (MAX_OUTSTANDING),
    .WIDTH (COUNT_WIDTH)
  ) u_counter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_inc       (np_fire),
    .i_dec       (resp_done),
    .o_count     (o_outstanding),
    .o_zero      (cnt_zero),
    .o_full      (cnt_full),
    .o_next_zero (cnt_next_zero),
    .o_underflow (cnt_underflow)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (np_fire) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        // Draining to zero wins: the waiting command fires from IDLE next cycle.
        if (cnt_next_zero) begin
          state_next = IDLE;
        end else if (i_scmd_valid && i_scmd_non_posted && !same_port) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_next_zero) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      active_select <= '0;
      error         <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && np_fire) begin
        active_select <= i_scmd_select;
      end
      if (cnt_underflow) begin
        error <= 1'b1;
      end
    end
  end

  assign o_active_select = active_select;
  assign o_busy          = (state != IDLE);
  assign o_error         = error;

`ifdef PZCOREBUS_1_TO_M_SWITCH_ORDER_GUARD_TIMEOUT_EN
  localparam int WD_WIDTH = calc_count_width(TIMEOUT_CYCLES);

  logic [WD_WIDTH-1:0] wd_count;
  logic                timeout;

  // Any response in DRAIN proves forward progress, so it restarts the watchdog.
  always_ff @(posedge i_clk) begin
    if (i_rst || (state != DRAIN) || resp_done) begin
      wd_count <= '0;
    end else if (wd_count != WD_WIDTH'(TIMEOUT_CYCLES)) begin
      wd_count <= wd_count + WD_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timeout <= 1'b0;
    end else if ((state == DRAIN) && (wd_count == WD_WIDTH'(TIMEOUT_CYCLES - 1))) begin
      timeout <= 1'b1;
    end
  end

  assign o_timeout = timeout;
`else
  // TIMEOUT_CYCLES is a positive limit, so this is a constant 0 with the watchdog compiled out.
  assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_pzcorebus_1_to_m_switch_order_guard.sv
// tb/tb_pzcorebus_1_to_m_switch_order_guard.sv - directed table-driven bench for the order guard
module tb_pzcorebus_1_to_m_switch_order_guard;

  localparam int SW = 1;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          scmd_valid;
  logic          scmd_accept;
  logic [SW-1:0] scmd_select;
  logic          scmd_non_posted;
  logic          mcmd_valid;
  logic          mcmd_accept;
  logic          resp_valid;
  logic          resp_accept;
  logic          resp_last;
  logic [SW-1:0] active_select;
  logic [CW-1:0] outstanding;
  logic          busy;
  logic          error;
  logic          timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pzcorebus_1_to_m_switch_order_guard #(
    .MASTERS         (2),
    .MAX_OUTSTANDING (8),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_scmd_valid      (scmd_valid),
    .o_scmd_accept     (scmd_accept),
    .i_scmd_select     (scmd_select),
    .i_scmd_non_posted (scmd_non_posted),
    .o_mcmd_valid      (mcmd_valid),
    .i_mcmd_accept     (mcmd_accept),
    .i_resp_valid      (resp_valid),
    .i_resp_accept     (resp_accept),
    .i_resp_last       (resp_last),
    .o_active_select   (active_select),
    .o_outstanding     (outstanding),
    .o_busy            (busy),
    .o_error           (error),
    .o_timeout         (timeout)
  );

  typedef struct {
    logic       v;
    logic       sel;
    logic       np;
    logic       acc;
    logic       rsp;
    logic       e_mv;
    logic       e_sa;
    logic [3:0] e_cnt;
    logic       e_busy;
    logic       e_asel;
    logic       e_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic np, input logic acc, input logic rsp);
    scmd_valid      = v;
    scmd_select     = sel;
    scmd_non_posted = np;
    mcmd_accept     = acc;
    resp_valid      = rsp;
    resp_accept     = rsp;
    resp_last       = rsp;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    // v sel np acc rsp | mv sa cnt busy asel err
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state; pass-through already open while in reset.
    do_reset();
    chk("rst_cnt", outstanding, 0);
    chk("rst_busy", busy, 0);
    chk("rst_asel", active_select, 0);
    chk("rst_err", error, 0);
    chk("rst_to", timeout, 0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("rst_mv", mcmd_valid, 1);
    chk("rst_sa", scmd_accept, 1);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Main table: posted pass, 3 np to port 0, port 1 stalls into DRAIN, drain, port 1 fires.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].np, vecs[i].acc, vecs[i].rsp);
      #1;
      chk($sformatf("row%0d_mv", i), mcmd_valid, vecs[i].e_mv);
      chk($sformatf("row%0d_sa", i), scmd_accept, vecs[i].e_sa);
      step();
      chk($sformatf("row%0d_cnt", i), outstanding, vecs[i].e_cnt);
      chk($sformatf("row%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("row%0d_asel", i), active_select, vecs[i].e_asel);
      chk($sformatf("row%0d_err", i), error, vecs[i].e_err);
    end

    // Saturation at 8, one response frees a slot for the 9th.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
    end
    chk("sat_cnt8", outstanding, 8);
    #1;
    chk("sat_mv_blocked", mcmd_valid, 0);
    chk("sat_sa_blocked", scmd_accept, 0);
    step();
    chk("sat_hold_cnt", outstanding, 8);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("sat_mv_still_blocked", mcmd_valid, 0);
    step();
    chk("sat_cnt7", outstanding, 7);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("sat_9th_mv", mcmd_valid, 1);
    chk("sat_9th_sa", scmd_accept, 1);
    step();
    chk("sat_cnt8_again", outstanding, 8);
    chk("sat_busy", busy, 1);

    // Simultaneous np_fire and resp_done at count 4.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
    end
    chk("sim_cnt4", outstanding, 4);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk("sim_cnt_still4", outstanding, 4);
    chk("sim_asel", active_select, 1);

    // Response in IDLE sets the sticky error.
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("err_set", error, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("err_sticky", error, 1);
    do_reset();
    chk("err_cleared", error, 0);

    // Reset mid-operation drops tracking; a late response then flags an error.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    step();
    chk("mid_cnt2", outstanding, 2);
    do_reset();
    chk("mid_rst_cnt", outstanding, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_asel", active_select, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("mid_late_err", error, 1);

    // Drain with no responses: watchdog only when compiled in.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("drain_same_port_blocked", mcmd_valid, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step();
    chk("to_before", timeout, 0);
    step();
`ifdef PZCOREBUS_1_TO_M_SWITCH_ORDER_GUARD_TIMEOUT_EN
    chk("to_set", timeout, 1);
    for (int i = 0; i < 4; i++) step();
    chk("to_sticky", timeout, 1);
`else
    chk("to_off", timeout, 0);
    for (int i = 0; i < 4; i++) step();
    chk("to_off_later", timeout, 0);
`endif
    chk("to_fsm_unchanged_cnt", outstanding, 1);
    chk("to_fsm_busy", busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
